// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin 4:1 arbiter slice.
package mux_arb_pkg;

  localparam int NUM_REQ   = 4;
  localparam int SEL_WIDTH = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set valid bit at or after start, wrapping mod 4.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [1:0]         start_i,
  output logic               found_o,
  output logic [1:0]         idx_o
);

  logic [1:0] cand [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand[gi] = start_i + 2'(gi);
  end

  // Walk from the farthest candidate back to start so the nearest one wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = start_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_i[cand[k]]) begin
        found_o = 1'b1;
        idx_o   = cand[k];
      end
    end
  end

endmodule

// File: rtl/mux_4to1_rr_arb.sv
// Round-robin arbiter sharing one registered 4:1 data path between four valid/ready requesters.
// An owner keeps the grant for up to BURST_LEN consecutive beats before priority rotates.
module mux_4to1_rr_arb #(
  parameter int WIDTH     = 64,
  parameter int SEL_WIDTH = 2,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req_valid,
  input  logic [WIDTH-1:0]     data0,
  input  logic [WIDTH-1:0]     data1,
  input  logic [WIDTH-1:0]     data2,
  input  logic [WIDTH-1:0]     data3,
  output logic [3:0]           req_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_sel,
  input  logic                 out_ready
);

  import mux_arb_pkg::*;

  localparam logic [3:0] BURST_CNT = 4'(BURST_LEN);

  arb_state_e           state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           owner_q, owner_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [SEL_WIDTH-1:0] out_sel_q;

  logic                 load_en;
  logic                 owner_hold;
  logic [1:0]           pick_start;
  logic                 pick_found;
  logic [1:0]           pick_idx;
  logic                 xfer;
  logic [1:0]           grant_idx;
  logic [WIDTH-1:0]     sel_data;

  assign load_en    = !out_valid_q || out_ready;
  assign owner_hold = (state_q == ARB_OWNED) && req_valid[owner_q];
  // A released owner hands priority to its neighbour in the same cycle, so no bubble appears.
  assign pick_start = (state_q == ARB_OWNED) ? wrap_inc(owner_q) : ptr_q;

  rr_pick4 u_pick (
    .valid_i (req_valid),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (load_en) begin
        out_valid_q <= xfer;
        if (xfer) begin
          out_data_q <= sel_data;
          out_sel_q  <= SEL_WIDTH'(grant_idx);
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    xfer      = 1'b0;
    grant_idx = pick_idx;
    if (load_en) begin
      if (owner_hold) begin
        xfer      = 1'b1;
        grant_idx = owner_q;
        cnt_d     = cnt_q + 4'd1;
        if ((cnt_q + 4'd1) == BURST_CNT) begin
          ptr_d   = wrap_inc(owner_q);
          state_d = ARB_IDLE;
        end
      end else if (pick_found) begin
        xfer = 1'b1;
        if (BURST_LEN == 1) begin
          ptr_d   = wrap_inc(pick_idx);
          state_d = ARB_IDLE;
        end else begin
          ptr_d   = pick_start;
          owner_d = pick_idx;
          cnt_d   = 4'd1;
          state_d = ARB_OWNED;
        end
      end else begin
        ptr_d   = pick_start;
        state_d = ARB_IDLE;
      end
    end
  end

  // Output logic
  always_comb begin
    req_ready = 4'b0000;
    if (xfer && rst_n) begin
      req_ready = 4'b0001 << grant_idx;
    end
    case (grant_idx)
      2'd0:    sel_data = data0;
      2'd1:    sel_data = data1;
      2'd2:    sel_data = data2;
      default: sel_data = data3;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
